// File: rtl/pmesh_msg_pkg.sv
// ============================================================================
// Module      : pmesh_msg_pkg
// Description : Shared L2<->memory message constants, widths and responder FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pmesh_msg_pkg;

  localparam logic [7:0] MSG_LOAD_MEM      = 8'd19;
  localparam logic [7:0] MSG_STORE_MEM     = 8'd20;
  localparam logic [7:0] MSG_LOAD_MEM_ACK  = 8'd24;
  localparam logic [7:0] MSG_STORE_MEM_ACK = 8'd25;

  localparam int TAG_W  = 26;
  localparam int DATA_W = 64;
  localparam int SRC_W  = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pmesh_mem_array.sv
// ============================================================================
// Module      : pmesh_mem_array
// Description : DEPTH x DATA_W register array, one write port, one async read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pmesh_mem_array
  import pmesh_msg_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/pmesh_mem_responder.sv
// ============================================================================
// Module      : pmesh_mem_responder
// Description : Memory-side stub answering LOAD_MEM/STORE_MEM after a fixed latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pmesh_mem_responder
  import pmesh_msg_pkg::*;
#(
  parameter int               DEPTH       = 16,
  parameter int               MEM_LATENCY = 4,
  parameter logic [SRC_W-1:0] MEM_SRC_ID  = 6'h3F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              msg2_valid,
  output logic              msg2_ready,
  input  logic [7:0]        msg2_type,
  input  logic [TAG_W-1:0]  msg2_tag,
  input  logic [DATA_W-1:0] msg2_data,
  output logic              msg3_valid,
  input  logic              msg3_ready,
  output logic [7:0]        msg3_type,
  output logic [TAG_W-1:0]  msg3_tag,
  output logic [DATA_W-1:0] msg3_data,
  output logic [SRC_W-1:0]  msg3_source,
  output logic              err_unsupported,
  output logic              busy
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [7:0] LAT_M1 = 8'(MEM_LATENCY - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [7:0]         r_cnt;
  logic [7:0]         w_cnt_nxt;
  logic [TAG_W-1:0]   r_tag;
  logic               r_is_store;
  logic               w_enter_resp;
  logic               w_accept;
  logic               w_is_load;
  logic               w_is_store;
  logic               w_mem_req;
  logic               w_resp_store;
  logic [TAG_W-1:0]   w_resp_tag;
  logic [DATA_W-1:0]  w_rdata;

  assign msg2_ready  = rst_n && (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign msg3_source = MEM_SRC_ID;

  assign w_accept   = msg2_valid && msg2_ready;
  assign w_is_load  = (msg2_type == MSG_LOAD_MEM);
  assign w_is_store = (msg2_type == MSG_STORE_MEM);
  assign w_mem_req  = w_accept && (w_is_load || w_is_store);

  // With a latency of 1 the response is built straight from the live request.
  assign w_resp_store = (r_state == IDLE) ? w_is_store : r_is_store;
  assign w_resp_tag   = (r_state == IDLE) ? msg2_tag   : r_tag;

  pmesh_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_accept && w_is_store),
    .waddr (msg2_tag[AW-1:0]),
    .wdata (msg2_data),
    .raddr (w_resp_tag[AW-1:0]),
    .rdata (w_rdata)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_mem_req) begin
          w_cnt_nxt = LAT_M1;
          if (MEM_LATENCY == 1) begin
            w_state_nxt  = RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = ACCESS;
          end
        end
      end
      ACCESS: begin
        // Counter reaches zero on the edge that enters RESP.
        if (r_cnt <= 8'd1) begin
          w_cnt_nxt    = 8'd0;
          w_state_nxt  = RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      RESP: begin
        if (msg3_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_cnt           <= 8'd0;
      r_tag           <= '0;
      r_is_store      <= 1'b0;
      msg3_valid      <= 1'b0;
      msg3_type       <= 8'd0;
      msg3_tag        <= '0;
      msg3_data       <= '0;
      err_unsupported <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      err_unsupported <= w_accept && !w_is_load && !w_is_store;
      if (w_mem_req) begin
        r_tag      <= msg2_tag;
        r_is_store <= w_is_store;
      end
      if (w_enter_resp) begin
        msg3_valid <= 1'b1;
        msg3_type  <= w_resp_store ? MSG_STORE_MEM_ACK : MSG_LOAD_MEM_ACK;
        msg3_tag   <= w_resp_tag;
        msg3_data  <= w_resp_store ? '0 : w_rdata;
      end else if ((r_state == RESP) && msg3_ready) begin
        msg3_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pmesh_mem_responder.sv
// ============================================================================
// Module      : tb_pmesh_mem_responder
// Description : Directed + randomized bench with an array-based memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pmesh_mem_responder;

  localparam int         DEPTH = 16;
  localparam int         LAT   = 4;
  localparam logic [5:0] SRC   = 6'h3F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        msg2_valid = 1'b0;
  logic        msg2_ready;
  logic [7:0]  msg2_type = 8'd0;
  logic [25:0] msg2_tag = '0;
  logic [63:0] msg2_data = '0;
  logic        msg3_valid;
  logic        msg3_ready = 1'b0;
  logic [7:0]  msg3_type;
  logic [25:0] msg3_tag;
  logic [63:0] msg3_data;
  logic [5:0]  msg3_source;
  logic        err_unsupported;
  logic        busy;

  int checks = 0;
  int failures = 0;
  logic [63:0] model [DEPTH];

  pmesh_mem_responder #(
    .DEPTH       (DEPTH),
    .MEM_LATENCY (LAT),
    .MEM_SRC_ID  (SRC)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .msg2_valid      (msg2_valid),
    .msg2_ready      (msg2_ready),
    .msg2_type       (msg2_type),
    .msg2_tag        (msg2_tag),
    .msg2_data       (msg2_data),
    .msg3_valid      (msg3_valid),
    .msg3_ready      (msg3_ready),
    .msg3_type       (msg3_type),
    .msg3_tag        (msg3_tag),
    .msg3_data       (msg3_data),
    .msg3_source     (msg3_source),
    .err_unsupported (err_unsupported),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = 64'd0;
  endtask

  // Assert reset between clock edges and verify every output drops at once.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    clear_model();
    chk({tag, "_valid"}, 64'(msg3_valid), 64'd0);
    chk({tag, "_ready"}, 64'(msg2_ready), 64'd0);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_err"},   64'(err_unsupported), 64'd0);
    chk({tag, "_type"},  64'(msg3_type), 64'd0);
    chk({tag, "_tag"},   64'(msg3_tag), 64'd0);
    chk({tag, "_data"},  msg3_data, 64'd0);
    chk({tag, "_src"},   64'(msg3_source), 64'(SRC));
    msg2_valid = 1'b0;
    msg3_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk({tag, "_ready_after"}, 64'(msg2_ready), 64'd1);
    @(negedge clk);
  endtask

  // Present one request at a negedge; returns at the negedge of cycle T+1.
  task automatic issue(input logic [7:0] typ, input logic [25:0] tag, input logic [63:0] data);
    int n = 0;
    while (!msg2_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 64'(msg2_ready), 64'd1);
    msg2_valid = 1'b1;
    msg2_type  = typ;
    msg2_tag   = tag;
    msg2_data  = data;
    @(negedge clk);
    msg2_valid = 1'b0;
    msg2_type  = 8'($urandom);
    msg2_tag   = 26'($urandom);
    msg2_data  = {$urandom, $urandom};
  endtask

  // Full transaction with latency, content, stability and handshake checks.
  task automatic transact(input logic [7:0] typ, input logic [25:0] tag,
                          input logic [63:0] data, input int stall);
    logic        is_mem;
    logic [7:0]  e_type;
    logic [63:0] e_data;
    int          idx;
    idx    = int'(tag) % DEPTH;
    is_mem = (typ == 8'd19) || (typ == 8'd20);
    e_type = (typ == 8'd20) ? 8'd25 : 8'd24;
    e_data = (typ == 8'd20) ? 64'd0 : model[idx];
    if (typ == 8'd20) model[idx] = data;
    issue(typ, tag, data);
    if (!is_mem) begin
      chk("unsup_err_hi", 64'(err_unsupported), 64'd1);
      chk("unsup_busy",   64'(busy), 64'd0);
      chk("unsup_valid",  64'(msg3_valid), 64'd0);
      @(negedge clk);
      chk("unsup_err_lo", 64'(err_unsupported), 64'd0);
      chk("unsup_valid2", 64'(msg3_valid), 64'd0);
      return;
    end
    for (int k = 1; k < LAT; k++) begin
      chk("lat_valid_lo", 64'(msg3_valid), 64'd0);
      chk("lat_busy",     64'(busy), 64'd1);
      chk("lat_ready_lo", 64'(msg2_ready), 64'd0);
      msg3_ready = 1'($urandom);
      msg2_valid = 1'($urandom);
      msg2_type  = 8'd19;
      @(negedge clk);
    end
    msg2_valid = 1'b0;
    msg3_ready = 1'b0;
    chk("resp_valid", 64'(msg3_valid), 64'd1);
    for (int s = 0; s <= stall; s++) begin
      chk("resp_type", 64'(msg3_type), 64'(e_type));
      chk("resp_tag",  64'(msg3_tag), 64'(tag));
      chk("resp_data", msg3_data, e_data);
      chk("resp_src",  64'(msg3_source), 64'(SRC));
      if (s < stall) begin
        chk("stall_valid", 64'(msg3_valid), 64'd1);
        chk("stall_ready", 64'(msg2_ready), 64'd0);
        msg2_valid = 1'b1;
        msg2_type  = 8'd20;
        @(negedge clk);
      end
    end
    msg2_valid = 1'b0;
    msg3_ready = 1'b1;
    @(negedge clk);
    msg3_ready = 1'b0;
    chk("post_valid", 64'(msg3_valid), 64'd0);
    chk("post_ready", 64'(msg2_ready), 64'd1);
    chk("post_busy",  64'(busy), 64'd0);
  endtask

  initial begin
    logic [7:0] typ;
    clear_model();
    #3;
    chk("rst_valid", 64'(msg3_valid), 64'd0);
    chk("rst_ready", 64'(msg2_ready), 64'd0);
    chk("rst_src",   64'(msg3_source), 64'(SRC));
    chk("rst_err",   64'(err_unsupported), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 64'(msg2_ready), 64'd1);
    chk("rel_busy",  64'(busy), 64'd0);
    @(negedge clk);

    transact(8'd19, 26'h0000005, 64'd0, 0);
    transact(8'd20, 26'h3, 64'hDEADBEEF_CAFEF00D, 0);
    transact(8'd19, 26'h3, 64'd0, 0);
    transact(8'd19, 26'h3, 64'd0, 5);
    transact(8'd7,  26'h1, 64'd0, 0);
    transact(8'd20, 26'h10, 64'h1, 2);
    transact(8'd19, 26'h20, 64'd0, 0);

    // Reset while in ACCESS.
    transact(8'd20, 26'h9, 64'h1234_5678_9ABC_DEF0, 0);
    issue(8'd19, 26'h9, 64'd0);
    chk("mid_access_busy", 64'(busy), 64'd1);
    async_reset("rst_access");
    transact(8'd19, 26'h9, 64'd0, 0);

    // Reset while in RESP with backpressure.
    transact(8'd20, 26'h7, 64'hA5A5_5A5A_0F0F_F0F0, 0);
    issue(8'd19, 26'h7, 64'd0);
    repeat (LAT - 1) @(negedge clk);
    chk("mid_resp_valid", 64'(msg3_valid), 64'd1);
    chk("mid_resp_data",  msg3_data, 64'hA5A5_5A5A_0F0F_F0F0);
    async_reset("rst_resp");
    transact(8'd19, 26'h7, 64'd0, 0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0, 1:    typ = 8'd19;
        2, 3:    typ = 8'd20;
        default: typ = 8'($urandom_range(0, 17));
      endcase
      transact(typ, {22'($urandom_range(0, 3)), 4'($urandom)}, {$urandom, $urandom},
               int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
